// File: rtl/wb_stream_writer_ctrl.sv
// wb_stream_writer_ctrl
//   Sequencing engine for the Wishbone stream writer. On an enable pulse it
//   latches start address, length and burst size. It then reads the buffer as
//   a Wishbone B3 master using incrementing bursts, and pushes each returned
//   word into the output FIFO. A burst is only launched when the FIFO can take
//   all of its beats. Completion is signalled by a one-cycle done pulse.
//
// Ports
//   wb_clk_i, wb_rst_ni            clock, async active-low reset
//   enable, start_adr, buf_size,   configuration (sampled on accepted enable)
//   burst_size
//   wbm_*                          Wishbone B3 read master
//   fifo_d, fifo_wr, fifo_free     output FIFO write side
//   busy, done, err                status
//
// Optional feature
//   WB_STREAM_WRITER_CTRL_ERR_EN   when defined, wbm_err_i aborts the transfer
//                                  into ERROR and sets the sticky err flag.
//                                  When undefined, wbm_err_i acts as an ack.
module wb_stream_writer_ctrl #(
  parameter int WB_AW = 32,
  parameter int WB_DW = 32
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  input  logic               enable,
  input  logic [WB_AW-1:0]   start_adr,
  input  logic [WB_AW-1:0]   buf_size,
  input  logic [WB_AW-1:0]   burst_size,
  output logic [WB_AW-1:0]   wbm_adr_o,
  output logic [WB_DW-1:0]   wbm_dat_o,
  output logic [WB_DW/8-1:0] wbm_sel_o,
  output logic               wbm_we_o,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic [2:0]         wbm_cti_o,
  output logic [1:0]         wbm_bte_o,
  input  logic [WB_DW-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  output logic [WB_DW-1:0]   fifo_d,
  output logic               fifo_wr,
  input  logic [WB_AW-1:0]   fifo_free,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [WB_AW-1:0] STRIDE = WB_AW'(WB_DW / 8);
  localparam logic [WB_AW-1:0] ONE    = WB_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_BURST,
    S_FINISH
`ifdef WB_STREAM_WRITER_CTRL_ERR_EN
    , S_ERROR
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WB_AW-1:0] adr_q, remaining_q, beats_q, bsz_q;
  logic [WB_AW-1:0] blen;
  logic             in_burst, beat, room;

  assign in_burst = (state_q == S_BURST);
  // bsz_q already holds max(burst_size,1), so only the tail clamp is needed
  assign blen     = (bsz_q < remaining_q) ? bsz_q : remaining_q;
  assign room     = (fifo_free >= blen);

`ifdef WB_STREAM_WRITER_CTRL_ERR_EN
  // error wins over a simultaneous ack: the beat is neither counted nor written
  assign beat = in_burst & wbm_ack_i & ~wbm_err_i;
`else
  assign beat = in_burst & (wbm_ack_i | wbm_err_i);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (enable) state_d = (buf_size == '0) ? S_FINISH : S_WAIT_SPACE;
      S_WAIT_SPACE: if (room) state_d = S_BURST;
      S_BURST: begin
`ifdef WB_STREAM_WRITER_CTRL_ERR_EN
        if (wbm_err_i) state_d = S_ERROR;
        else
`endif
        if (beat && beats_q == ONE)
          state_d = (remaining_q == ONE) ? S_FINISH : S_WAIT_SPACE;
      end
      S_FINISH:     state_d = S_IDLE;
`ifdef WB_STREAM_WRITER_CTRL_ERR_EN
      S_ERROR:      state_d = S_IDLE;
`endif
      default:      state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      bsz_q       <= ONE;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && enable) begin
        adr_q       <= start_adr;
        remaining_q <= buf_size;
        bsz_q       <= (burst_size == '0) ? ONE : burst_size;
      end
      if (state_q == S_WAIT_SPACE && room) beats_q <= blen;
      if (beat) begin
        adr_q       <= adr_q + STRIDE;
        remaining_q <= remaining_q - ONE;
        beats_q     <= beats_q - ONE;
      end
    end
  end

`ifdef WB_STREAM_WRITER_CTRL_ERR_EN
  logic err_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                        err_q <= 1'b0;
    else if (state_q == S_IDLE && enable)  err_q <= 1'b0;
    else if (in_burst && wbm_err_i)        err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // cyc/stb decode straight from the state register so reset drops them at once
  assign wbm_cyc_o = in_burst;
  assign wbm_stb_o = in_burst;
  assign wbm_adr_o = adr_q;
  assign wbm_cti_o = !in_burst ? 3'b000 : (beats_q == ONE) ? 3'b111 : 3'b010;
  assign wbm_dat_o = '0;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_bte_o = 2'b00;

  assign fifo_d  = wbm_dat_i;
  assign fifo_wr = beat;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_FINISH);

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
module tb_wb_stream_writer_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0, buf_size = '0, burst_size = '0, fifo_free = '0;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, fifo_d;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic        fifo_wr, busy, done, err;

  always #5 clk = ~clk;

  wb_stream_writer_ctrl #(.WB_AW(32), .WB_DW(32)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .enable(enable), .start_adr(start_adr),
    .buf_size(buf_size), .burst_size(burst_size), .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .fifo_d(fifo_d), .fifo_wr(fifo_wr),
    .fifo_free(fifo_free), .busy(busy), .done(done), .err(err));

  int total = 0, bad = 0;
  int wr_cnt, done_cnt, burst_cnt, sbeat;
  int err_beat = 0;
  bit waits_on = 1'b0, gate = 1'b1, cyc_prev = 1'b0;

  typedef struct { logic [31:0] adr; logic [2:0] cti; logic [31:0] dat; } exp_t;
  exp_t q[$];

  typedef struct {
    logic [31:0] sadr, bsize, burst, free;
    bit          waits;
    int          exp_bursts;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [31:0] dat_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endfunction

  // slave: memory data derived from address, optional random wait states,
  // error injected on a chosen beat of the transfer
  assign wbm_dat_i = dat_of(wbm_adr_o);
  assign wbm_err_i = wbm_cyc_o && wbm_stb_o && err_beat != 0 && sbeat == err_beat - 1;
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && gate && !wbm_err_i;

  always @(posedge clk) begin
    #2;
    gate = waits_on ? bit'($urandom_range(0, 1)) : 1'b1;
  end

  // monitor: compares each FIFO write against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (wbm_cyc_o && !cyc_prev) burst_cnt++;
    cyc_prev = wbm_cyc_o;
    if (done) done_cnt++;
    if (fifo_wr) begin
      wr_cnt++;
      if (q.size() == 0) chk("beat_unexpected", wbm_adr_o, 32'hxxxx_xxxx);
      else begin
        e = q.pop_front();
        chk("beat_adr", wbm_adr_o, e.adr);
        chk("beat_cti", {29'd0, wbm_cti_o}, {29'd0, e.cti});
        chk("beat_data", fifo_d, e.dat);
      end
    end
    if (wbm_cyc_o && (wbm_ack_i || wbm_err_i)) sbeat++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_expected(logic [31:0] sadr, logic [31:0] bsize,
                               logic [31:0] burst, int limit);
    logic [31:0] a = sadr, rem = bsize, b, blen;
    int n = 0;
    b = (burst == 0) ? 32'd1 : burst;
    while (rem != 0) begin
      blen = (b < rem) ? b : rem;
      for (int k = 0; k < int'(blen); k++) begin
        if (limit < 0 || n < limit)
          q.push_back('{a, (k == int'(blen) - 1) ? 3'b111 : 3'b010, dat_of(a)});
        n++;
        a += 32'd4;
      end
      rem -= blen;
    end
  endtask

  task automatic setup(logic [31:0] sadr, logic [31:0] bsize, logic [31:0] burst,
                       logic [31:0] free);
    start_adr = sadr; buf_size = bsize; burst_size = burst; fifo_free = free;
    wr_cnt = 0; done_cnt = 0; burst_cnt = 0; sbeat = 0;
  endtask

  task automatic pulse_enable();
    enable = 1'b1; tick(); enable = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int i;
    for (i = 0; i < 2000; i++) begin
      if (!busy) break;
      tick();
    end
    chk({name, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h1000, 8, 4, 16, 1'b0, 2};
    vecs[1] = '{32'h1000, 6, 4, 4, 1'b0, 2};   // fifo_free exactly equals burst
    vecs[2] = '{32'h0040, 3, 0, 16, 1'b0, 3};  // burst_size 0 acts as 1
    vecs[3] = '{32'hFFFF_FFF8, 4, 8, 16, 1'b0, 1}; // address wrap
    vecs[4] = '{32'h0200, 7, 3, 3, 1'b1, 3};   // random wait states
    vecs[5] = '{32'h0300, 5, 1, 16, 1'b1, 5};

    // reset state
    tick(); tick();
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 0);
    chk("rst_stb", {31'd0, wbm_stb_o}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_fifo_wr", {31'd0, fifo_wr}, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_cti", {29'd0, wbm_cti_o}, 0);
    chk("ties", {wbm_dat_o[0], wbm_we_o, wbm_bte_o, wbm_sel_o}, 32'h0000_000F);
    rst_n = 1'b1; tick();

    // table-driven transfers
    foreach (vecs[i]) begin
      setup(vecs[i].sadr, vecs[i].bsize, vecs[i].burst, vecs[i].free);
      waits_on = vecs[i].waits;
      push_expected(vecs[i].sadr, vecs[i].bsize, vecs[i].burst, -1);
      pulse_enable();
      wait_idle("vec");
      tick();
      chk("vec_writes", wr_cnt, vecs[i].bsize);
      chk("vec_done", done_cnt, 1);
      chk("vec_bursts", burst_cnt, vecs[i].exp_bursts);
      chk("vec_queue_left", q.size(), 0);
    end
    waits_on = 1'b0;

    // exact start/completion latency
    setup(32'h2000, 2, 2, 16);
    push_expected(32'h2000, 2, 2, -1);
    pulse_enable();
    chk("lat_busy", {31'd0, busy}, 1);
    chk("lat_cyc0", {31'd0, wbm_cyc_o}, 0);
    start_adr = 32'hDEAD_0000; buf_size = 9;  // must not affect running transfer
    tick();
    chk("lat_cyc1", {31'd0, wbm_cyc_o}, 1);
    chk("lat_cti_first", {29'd0, wbm_cti_o}, 3'b010);
    tick();
    chk("lat_cti_last", {29'd0, wbm_cti_o}, 3'b111);
    tick();
    chk("lat_done", {30'd0, done, busy}, 32'd3);
    chk("lat_cyc_off", {31'd0, wbm_cyc_o}, 0);
    tick();
    chk("lat_idle", {30'd0, done, busy}, 32'd0);
    chk("lat_writes", wr_cnt, 2);

    // stall for FIFO space
    setup(32'h3000, 4, 4, 2);
    push_expected(32'h3000, 4, 4, -1);
    pulse_enable();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_cyc", {30'd0, wbm_cyc_o, busy}, 32'd1);
    end
    fifo_free = 4;
    tick();
    chk("stall_release", {31'd0, wbm_cyc_o}, 1);
    wait_idle("stall");
    chk("stall_writes", wr_cnt, 4);

    // zero-length transfer
    setup(32'h4000, 0, 4, 16);
    pulse_enable();
    chk("zero_done", {30'd0, done, busy}, 32'd3);
    tick();
    chk("zero_idle", {30'd0, done, busy}, 32'd0);
    chk("zero_no_cyc", burst_cnt, 0);

    // bus error on beat 2
    setup(32'h5000, 4, 4, 16);
    err_beat = 2;
`ifdef WB_STREAM_WRITER_CTRL_ERR_EN
    push_expected(32'h5000, 4, 4, 1);
    pulse_enable();
    wait_idle("err");
    tick();
    chk("err_flag", {31'd0, err}, 1);
    chk("err_writes", wr_cnt, 1);
    chk("err_done", done_cnt, 0);
    err_beat = 0;
    setup(32'h5000, 1, 1, 16);
    push_expected(32'h5000, 1, 1, -1);
    pulse_enable();
    chk("err_clear", {31'd0, err}, 0);
    wait_idle("err2");
`else
    push_expected(32'h5000, 4, 4, -1);
    pulse_enable();
    wait_idle("err");
    tick();
    chk("err_flag", {31'd0, err}, 0);
    chk("err_writes", wr_cnt, 4);
    chk("err_done", done_cnt, 1);
    err_beat = 0;
`endif
    chk("err_queue_left", q.size(), 0);

    // reset in the middle of a burst
    setup(32'h6000, 8, 8, 16);
    push_expected(32'h6000, 8, 8, -1);
    pulse_enable();
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_off", {29'd0, wbm_cyc_o, wbm_stb_o, busy}, 32'd0);
    q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    setup(32'h6000, 8, 8, 16);
    push_expected(32'h6000, 8, 8, -1);
    pulse_enable();
    wait_idle("midrst");
    tick();
    chk("midrst_writes", wr_cnt, 8);
    chk("midrst_done", done_cnt, 1);
    chk("midrst_queue_left", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
